// File: rtl/regfile_pkg.sv
// Shared constants for the register-file read arbiter slice.
package regfile_pkg;

    localparam int              REG_ADDR_W     = 4;
    localparam int              NUM_REGS       = 16;
    localparam int              DATA_W_DEFAULT = 32;
    localparam logic [3:0]      REG_RA         = 4'd15;

    // Scoreboard query slots used by the arbiter.
    localparam int              Q_SRC1 = 0;
    localparam int              Q_SRC2 = 1;
    localparam int              Q_DEST = 2;
    localparam int              Q_DBG  = 3;
    localparam int              NUM_Q  = 4;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared on writeback.
// Answers hazard/forward-hit queries for several addresses at once.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NQ = NUM_Q
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_set_en,
    input  logic [REG_ADDR_W-1:0]      i_set_addr,
    input  logic                       i_wb_en,
    input  logic [REG_ADDR_W-1:0]      i_wb_addr,
    input  logic [NQ*REG_ADDR_W-1:0]   i_q_addr,
    output logic [NQ-1:0]              o_hazard,
    output logic [NQ-1:0]              o_hit
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            // Issue wins over a same-cycle writeback to the same register.
            assign w_busy_next[gi] =
                (i_set_en && i_set_addr == REG_ADDR_W'(gi)) ? 1'b1 :
                (i_wb_en  && i_wb_addr  == REG_ADDR_W'(gi)) ? 1'b0 :
                r_busy[gi];
        end

        for (gi = 0; gi < NQ; gi++) begin : g_query
            logic [REG_ADDR_W-1:0] w_addr;
            assign w_addr       = i_q_addr[gi*REG_ADDR_W +: REG_ADDR_W];
            assign o_hit[gi]    = i_wb_en && (i_wb_addr == w_addr);
            assign o_hazard[gi] = r_busy[w_addr] & ~o_hit[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the two register-file read ports between operand fetch and debug,
// stalls OF on scoreboard hazards and forwards same-cycle writeback data.
module regfile_read_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   of_valid,
    output logic                   of_ready,
    input  logic [REG_ADDR_W-1:0]  of_rs1,
    input  logic [REG_ADDR_W-1:0]  of_rs2,
    input  logic [REG_ADDR_W-1:0]  of_rd,
    input  logic                   of_wr,
    input  logic                   of_isRet,
    input  logic                   of_isSt,
    output logic [REG_ADDR_W-1:0]  rf_raddr1,
    output logic [REG_ADDR_W-1:0]  rf_raddr2,
    input  logic [DATA_W-1:0]      rf_rdata1,
    input  logic [DATA_W-1:0]      rf_rdata2,
    input  logic                   wb_en,
    input  logic [REG_ADDR_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   op_valid,
    output logic [DATA_W-1:0]      op1,
    output logic [DATA_W-1:0]      op2,
    input  logic                   dbg_req,
    input  logic [REG_ADDR_W-1:0]  dbg_addr,
    output logic                   dbg_gnt,
    output logic                   dbg_rvalid,
    output logic [DATA_W-1:0]      dbg_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]             r_starve_cnt;
    logic                         r_op_valid;
    logic [DATA_W-1:0]            r_op1;
    logic [DATA_W-1:0]            r_op2;
    logic                         r_dbg_rvalid;
    logic [DATA_W-1:0]            r_dbg_rdata;

    logic                         w_is_ret;
    logic [REG_ADDR_W-1:0]        w_src1;
    logic [NUM_Q*REG_ADDR_W-1:0]  w_q_addr;
    logic [NUM_Q-1:0]             w_hazard;
    logic [NUM_Q-1:0]             w_hit;
    logic                         w_stall;
    logic                         w_force_dbg;
    logic                         w_of_ready;
    logic                         w_dbg_gnt;
    logic [DATA_W-1:0]            w_op1_data;
    logic [DATA_W-1:0]            w_op2_data;
    logic [DATA_W-1:0]            w_dbg_data;

    // ret and st never decode together; should both appear, st is honoured.
    assign w_is_ret = of_isRet & ~of_isSt;
    assign w_src1   = w_is_ret ? REG_RA : of_rs1;
    assign w_q_addr = {dbg_addr, of_rd, of_rs2, w_src1};

    regfile_scoreboard #(.NQ(NUM_Q)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_of_ready & of_wr),
        .i_set_addr (of_rd),
        .i_wb_en    (wb_en),
        .i_wb_addr  (wb_addr),
        .i_q_addr   (w_q_addr),
        .o_hazard   (w_hazard),
        .o_hit      (w_hit)
    );

    assign w_stall     = w_hazard[Q_SRC1]
                       | (~w_is_ret & w_hazard[Q_SRC2])
                       | (of_wr & w_hazard[Q_DEST]);
    assign w_force_dbg = dbg_req && (r_starve_cnt == CNT_W'(STARVE_MAX));
    assign w_of_ready  = of_valid & ~w_stall & ~w_force_dbg;
    assign w_dbg_gnt   = dbg_req & ~w_of_ready;

    assign rf_raddr1 = w_dbg_gnt ? dbg_addr : w_src1;
    assign rf_raddr2 = of_rs2;

    assign w_op1_data = w_hit[Q_SRC1] ? wb_data : rf_rdata1;
    assign w_op2_data = w_is_ret      ? '0
                      : w_hit[Q_SRC2] ? wb_data : rf_rdata2;
    assign w_dbg_data = w_hit[Q_DBG]  ? wb_data : rf_rdata1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!dbg_req || w_dbg_gnt) begin
            r_starve_cnt <= '0;
        end else if (w_of_ready && r_starve_cnt != CNT_W'(STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_valid   <= 1'b0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= '0;
        end else begin
            r_op_valid   <= w_of_ready;
            r_dbg_rvalid <= w_dbg_gnt;
            if (w_of_ready) begin
                r_op1 <= w_op1_data;
                r_op2 <= w_op2_data;
            end
            if (w_dbg_gnt) begin
                r_dbg_rdata <= w_dbg_data;
            end
        end
    end

    assign of_ready   = w_of_ready;
    assign dbg_gnt    = w_dbg_gnt;
    assign op_valid   = r_op_valid;
    assign op1        = r_op1;
    assign op2        = r_op2;
    assign dbg_rvalid = r_dbg_rvalid;
    assign dbg_rdata  = r_dbg_rdata;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a static register-file model.
module tb_regfile_read_arbiter;

    logic        clk;
    logic        rst;
    logic        of_valid;
    logic        of_ready;
    logic [3:0]  of_rs1, of_rs2, of_rd;
    logic        of_wr, of_isRet, of_isSt;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        op_valid;
    logic [31:0] op1, op2;
    logic        dbg_req;
    logic [3:0]  dbg_addr;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;

    logic [31:0] rf [16];
    int n_checks = 0;
    int n_errors = 0;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    regfile_read_arbiter #(.DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .of_valid(of_valid), .of_ready(of_ready),
        .of_rs1(of_rs1), .of_rs2(of_rs2), .of_rd(of_rd),
        .of_wr(of_wr), .of_isRet(of_isRet), .of_isSt(of_isSt),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .op_valid(op_valid), .op1(op1), .op2(op2),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic of_set(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [3:0] rd, input logic wr, input logic ret, input logic st);
        of_valid = v; of_rs1 = rs1; of_rs2 = rs2; of_rd = rd;
        of_wr = wr; of_isRet = ret; of_isSt = st;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + i;
        rf[2] = 32'h40; rf[3] = 32'hAB; rf[15] = 32'h100;
        rst = 1'b1;
        of_set(0, 0, 0, 0, 0, 0, 0);
        wb_en = 0; wb_addr = 0; wb_data = 0;
        dbg_req = 0; dbg_addr = 0;
        next_cycle(); next_cycle();

        // Reset state
        chk("rst_op_valid", {31'd0, op_valid}, 0);
        chk("rst_op1", op1, 0);
        chk("rst_op2", op2, 0);
        chk("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        chk("rst_busy", {16'd0, dut.u_sb.r_busy}, 0);
        rst = 1'b0;
        next_cycle();

        // ret reads R15 only
        of_set(1, 4'd0, 4'd7, 4'd0, 0, 1, 0);
        #1;
        chk("ret_ready", {31'd0, of_ready}, 1);
        chk("ret_raddr1", {28'd0, rf_raddr1}, 15);
        next_cycle();
        chk("ret_op_valid", {31'd0, op_valid}, 1);
        chk("ret_op1", op1, 32'h100);
        chk("ret_op2", op2, 0);
        of_set(0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        chk("idle_op_valid", {31'd0, op_valid}, 0);
        chk("idle_op1_hold", op1, 32'h100);

        // add rd=3 issues, dependent add stalls until writeback forwards
        of_set(1, 4'd1, 4'd2, 4'd3, 1, 0, 0);
        #1;
        chk("add1_ready", {31'd0, of_ready}, 1);
        next_cycle();
        chk("add1_op1", op1, 32'h1001);
        of_set(1, 4'd3, 4'd4, 4'd6, 1, 0, 0);
        #1;
        chk("raw_stall0", {31'd0, of_ready}, 0);
        next_cycle();
        chk("raw_no_op", {31'd0, op_valid}, 0);
        #1;
        chk("raw_stall1", {31'd0, of_ready}, 0);
        wb_en = 1; wb_addr = 4'd3; wb_data = 32'h55;
        #1;
        chk("raw_release", {31'd0, of_ready}, 1);
        next_cycle();
        chk("raw_op_valid", {31'd0, op_valid}, 1);
        chk("raw_fwd_op1", op1, 32'h55);
        chk("raw_op2", op2, 32'h1004);
        chk("raw_busy", {16'd0, dut.u_sb.r_busy}, 32'h0040);
        of_set(0, 0, 0, 0, 0, 0, 0);
        wb_addr = 4'd6; wb_data = 32'h66;
        next_cycle();
        wb_en = 0;

        // st reads rs1 and rs2
        of_set(1, 4'd2, 4'd3, 4'd0, 0, 0, 1);
        #1;
        chk("st_ready", {31'd0, of_ready}, 1);
        next_cycle();
        chk("st_op1", op1, 32'h40);
        chk("st_op2", op2, 32'hAB);

        // WAW stall and issue-beats-writeback on the same register
        of_set(1, 4'd0, 4'd0, 4'd5, 1, 0, 0);
        next_cycle();
        chk("waw_busy_set", {16'd0, dut.u_sb.r_busy}, 32'h0020);
        #1;
        chk("waw_stall", {31'd0, of_ready}, 0);
        wb_en = 1; wb_addr = 4'd5; wb_data = 32'h77;
        #1;
        chk("waw_release", {31'd0, of_ready}, 1);
        next_cycle();
        chk("waw_set_wins", {16'd0, dut.u_sb.r_busy}, 32'h0020);
        of_set(0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        wb_en = 0;
        chk("waw_cleared", {16'd0, dut.u_sb.r_busy}, 0);

        // Starvation: OF wins 4 times, then debug is forced
        of_set(1, 4'd1, 4'd4, 4'd0, 0, 0, 0);
        dbg_req = 1; dbg_addr = 4'd2;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk($sformatf("starve_of_ready_c%0d", c), {31'd0, of_ready}, 1);
            chk($sformatf("starve_gnt_c%0d", c), {31'd0, dbg_gnt}, 0);
            next_cycle();
        end
        #1;
        chk("force_of_ready", {31'd0, of_ready}, 0);
        chk("force_gnt", {31'd0, dbg_gnt}, 1);
        chk("force_raddr1", {28'd0, rf_raddr1}, 2);
        next_cycle();
        chk("force_rvalid", {31'd0, dbg_rvalid}, 1);
        chk("force_rdata", dbg_rdata, 32'h40);
        chk("force_no_op", {31'd0, op_valid}, 0);
        dbg_req = 0;
        #1;
        chk("after_dbg_ready", {31'd0, of_ready}, 1);
        next_cycle();
        chk("after_dbg_rvalid", {31'd0, dbg_rvalid}, 0);
        chk("after_dbg_rdata_hold", dbg_rdata, 32'h40);

        // Debug with idle OF is granted at once, with writeback forwarding
        of_set(0, 0, 0, 0, 0, 0, 0);
        dbg_req = 1; dbg_addr = 4'd9;
        wb_en = 1; wb_addr = 4'd9; wb_data = 32'hBEEF;
        #1;
        chk("idle_dbg_gnt", {31'd0, dbg_gnt}, 1);
        next_cycle();
        dbg_req = 0; wb_en = 0;
        chk("idle_dbg_fwd", dbg_rdata, 32'hBEEF);

        // Fill every busy bit, then reset asynchronously
        for (int r = 0; r < 16; r++) begin
            of_set(1, 4'd15, 4'd15, 4'(r), 1, 0, 0);
            next_cycle();
        end
        of_set(0, 0, 0, 0, 0, 0, 0);
        chk("fill_busy", {16'd0, dut.u_sb.r_busy}, 32'hFFFF);
        chk("fill_op_valid", {31'd0, op_valid}, 1);
        rst = 1'b1;
        #1;
        chk("arst_op_valid", {31'd0, op_valid}, 0);
        chk("arst_op1", op1, 0);
        chk("arst_dbg_rdata", dbg_rdata, 0);
        chk("arst_busy", {16'd0, dut.u_sb.r_busy}, 0);
        next_cycle();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
